// File: rtl/rv_div_pkg.sv
// rv_div_pkg: shared definitions for the rv_div_iter divide unit.
//   - RISC-V M-extension divide op encodings (op_i field)
//   - FSM state encoding (also driven onto dbg_state_o)
//   - counter width helper for the per-bit step counter
package rv_div_pkg;

  localparam logic [1:0] DIV_OP  = 2'b00;
  localparam logic [1:0] DIVU_OP = 2'b01;
  localparam logic [1:0] REM_OP  = 2'b10;
  localparam logic [1:0] REMU_OP = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the step counter that walks XLEN-1 down to 0.
  function automatic int cnt_width(input int xlen);
    return $clog2(xlen);
  endfunction

endpackage

// File: rtl/rv_div_step.sv
// rv_div_step: one combinational restoring-division step.
// Ports:
//   r_i       partial remainder before the step (always < divisor)
//   dvd_msb_i next dividend bit shifted into the remainder
//   dsr_i     divisor magnitude
//   r_o       partial remainder after the step
//   q_bit_o   quotient bit produced by the step
module rv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] r_i,
  input  logic            dvd_msb_i,
  input  logic [XLEN-1:0] dsr_i,
  output logic [XLEN-1:0] r_o,
  output logic            q_bit_o
);

  // The shifted remainder keeps the bit that falls off the top of r_i:
  // with a divisor above 2^(XLEN-1) the remainder can itself have its msb
  // set, and dropping it would give a wrong trial result.
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] trial;

  always_comb begin
    shifted = {r_i, dvd_msb_i};
    trial   = {1'b0, shifted} - {2'b00, dsr_i};
    q_bit_o = ~trial[XLEN+1];
    // When the trial succeeds the difference is below the divisor, so
    // truncating to XLEN bits loses nothing.
    r_o     = q_bit_o ? XLEN'(trial) : XLEN'(shifted);
  end

endmodule

// File: rtl/rv_div_iter.sv
// rv_div_iter: multi-cycle RV32M/RV64M divider (DIV, DIVU, REM, REMU) using
// restoring division, one quotient bit per cycle.
// Optional feature macro: RV_DIV_FLUSH_EN (adds flush_i).
// Ports:
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   flush_i               (RV_DIV_FLUSH_EN only) discard operation, go IDLE
//   req_valid_i/req_ready_o  request handshake; op_i, a_i, b_i sampled on it
//   rsp_valid_o/rsp_ready_i  response handshake; result_o valid with it
//   busy_o                high while an operation is in CALC or DONE
//   dbg_state_o           current FSM state (rv_div_pkg::state_t encoding)
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. A producer holds valid (and its payload) until the
// transfer; rsp_valid_o never drops before its transfer. req_ready_o is high
// only in IDLE, so requests cannot overlap an operation or its response.
module rv_div_iter
  import rv_div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
`ifdef RV_DIV_FLUSH_EN
  input  logic            flush_i,
`endif
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o,
  output logic [1:0]      dbg_state_o
);

  localparam int CW = cnt_width(XLEN);

  logic flush;
`ifdef RV_DIV_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  state_t          state_q,   state_d;
  logic            is_rem_q,  is_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] dvd_q,     dvd_d;     // dividend, shifting into quotient
  logic [XLEN-1:0] dsr_q,     dsr_d;     // divisor magnitude
  logic [XLEN-1:0] rem_q,     rem_d;     // partial remainder
  logic [CW-1:0]   cnt_q,     cnt_d;
  logic [XLEN-1:0] result_q,  result_d;

  // Request decode
  logic            req_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            ovf_case;

  // Step datapath
  logic [XLEN-1:0] step_r;
  logic            step_q_bit;
  logic [XLEN-1:0] quo_fin;

  rv_div_step #(.XLEN(XLEN)) u_step (
    .r_i       (rem_q),
    .dvd_msb_i (dvd_q[XLEN-1]),
    .dsr_i     (dsr_q),
    .r_o       (step_r),
    .q_bit_o   (step_q_bit)
  );

  always_comb begin
    state_d   = state_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    result_d  = result_q;

    // op bit 0 clear = signed op, bit 1 set = remainder op.
    req_signed = ~op_i[0];
    a_neg      = req_signed & a_i[XLEN-1];
    b_neg      = req_signed & b_i[XLEN-1];
    // -x of the most-negative value is 1<<(XLEN-1), correct as unsigned.
    abs_a      = a_neg ? -a_i : a_i;
    abs_b      = b_neg ? -b_i : b_i;
    ovf_case   = req_signed && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);

    quo_fin    = {dvd_q[XLEN-2:0], step_q_bit};

    case (state_q)
      IDLE: begin
        if (req_valid_i && !flush) begin
          is_rem_d  = op_i[1];
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dvd_d     = abs_a;
          dsr_d     = abs_b;
          rem_d     = '0;
          cnt_d     = CW'(XLEN - 1);
          if (b_i == '0) begin
            state_d  = DONE;
            result_d = op_i[1] ? a_i : '1;
          end else if (ovf_case) begin
            state_d  = DONE;
            result_d = op_i[1] ? '0 : a_i;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_r;
        dvd_d = quo_fin;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          // Sign fixup folded into the final step so result_o is
          // registered on entry to DONE.
          if (is_rem_q) result_d = neg_rem_q ? -step_r : step_r;
          else          result_d = neg_quo_q ? -quo_fin : quo_fin;
        end
      end
      DONE: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  // All outputs decode directly from registered state.
  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == DONE);
  assign busy_o      = (state_q == CALC) || (state_q == DONE);
  assign result_o    = result_q;
  assign dbg_state_o = state_q;

endmodule
